// File: rtl/uart_rx.sv
// ============================================================================
// Module   : uart_rx
// Purpose  : Oversampled 8N1-style UART receiver. The start bit is qualified
//            at mid-bit, data is shifted in LSB first, and the stop bit is
//            checked for framing errors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 tick_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  output logic                 frame_err_o,
  output logic                 busy_o
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state, state_n;
  logic [TW-1:0]        tick_cnt, tick_cnt_n;
  logic [BW-1:0]        bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  logic [DATA_BITS-1:0] data_n;
  logic                 valid_n;
  logic                 frame_err_n;
  logic                 rx_meta, rx_s, rx_d;

  // Two-flop synchronizer plus one delay stage for falling-edge detection;
  // all stages reset to the idle-high line level.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      sh          <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      state       <= state_n;
      tick_cnt    <= tick_cnt_n;
      bit_cnt     <= bit_cnt_n;
      sh          <= sh_n;
      data_o      <= data_n;
      valid_o     <= valid_n;
      frame_err_o <= frame_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    tick_cnt_n  = tick_cnt;
    bit_cnt_n   = bit_cnt;
    sh_n        = sh;
    data_n      = data_o;
    valid_n     = 1'b0;
    frame_err_n = frame_err_o;

    unique case (state)
      IDLE: begin
        // Edge-triggered so a held-low (break) line cannot retrigger.
        if (!rx_s && rx_d) begin
          state_n    = START;
          tick_cnt_n = '0;
        end
      end
      START: begin
        if (tick_i) begin
          if (tick_cnt == HALF_LAST) begin
            tick_cnt_n = '0;
            bit_cnt_n  = '0;
            state_n    = rx_s ? IDLE : DATA;
          end else begin
            tick_cnt_n = tick_cnt + TW'(1);
          end
        end
      end
      DATA: begin
        if (tick_i) begin
          if (tick_cnt == BIT_LAST) begin
            sh_n       = {rx_s, sh[DATA_BITS-1:1]};
            tick_cnt_n = '0;
            bit_cnt_n  = bit_cnt + BW'(1);
            if (bit_cnt == DATA_LAST) begin
              state_n = STOP;
            end
          end else begin
            tick_cnt_n = tick_cnt + TW'(1);
          end
        end
      end
      STOP: begin
        if (tick_i) begin
          if (tick_cnt == BIT_LAST) begin
            // Data is delivered even when the stop bit is bad.
            data_n      = sh;
            frame_err_n = ~rx_s;
            valid_n     = 1'b1;
            tick_cnt_n  = '0;
            state_n     = IDLE;
          end else begin
            tick_cnt_n = tick_cnt + TW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy_o = (state != IDLE);

endmodule

`default_nettype wire
